// File: rtl/txhex_pkg.sv
// Shared definitions for the hex-string transmitter.
// Contents:
//   state_t    - formatter FSM states
//   CH_*       - fixed characters: "0", "x", CR, LF
//   hex2ascii  - one nibble to its ASCII hex digit, upper or lower case
package txhex_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PFX0 = 3'd1,
    S_PFXX = 3'd2,
    S_DIG  = 3'd3,
    S_CR   = 3'd4,
    S_LF   = 3'd5
  } state_t;

  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_X    = 8'h78;
  localparam logic [7:0] CH_CR   = 8'h0d;
  localparam logic [7:0] CH_LF   = 8'h0a;

  // 0x37 + 10 = 'A', 0x57 + 10 = 'a'
  function automatic logic [7:0] hex2ascii(input logic [3:0] nibble, input logic upper);
    logic [7:0] n8;
    n8 = {4'h0, nibble};
    if (nibble < 4'd10)
      return 8'h30 + n8;
    else if (upper)
      return 8'h37 + n8;
    else
      return 8'h57 + n8;
  endfunction

endpackage

// File: rtl/txuart.sv
// Minimal 8N1 UART transmitter (no reset).
// Ports:
//   clk     - clock
//   wr      - write strobe; the byte is taken when busy is low
//   data    - byte to send, LSB first
//   uart_tx - serial line, idles high
//   busy    - high from the cycle after a write until the stop bit ends
// Each bit, start and stop included, lasts CLOCKS_PER_BAUD cycles.
module txuart #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868
) (
  input  logic       clk,
  input  logic       wr,
  input  logic [7:0] data,
  output logic       uart_tx,
  output logic       busy
);

  logic [23:0] baud_cnt;
  logic [3:0]  bits_left;
  logic [8:0]  shreg;
  logic        busy_r;
  // The line is stored inverted so an all-zero power-up state idles high.
  logic        line_n;

  always_ff @(posedge clk) begin
    if (!busy_r) begin
      if (wr) begin
        busy_r    <= 1'b1;
        line_n    <= 1'b1;
        shreg     <= {1'b1, data};
        bits_left <= 4'd9;
        baud_cnt  <= CLOCKS_PER_BAUD - 24'd1;
      end
    end else if (baud_cnt != 24'd0) begin
      baud_cnt <= baud_cnt - 24'd1;
    end else if (bits_left != 4'd0) begin
      line_n    <= ~shreg[0];
      shreg     <= {1'b1, shreg[8:1]};
      bits_left <= bits_left - 4'd1;
      baud_cnt  <= CLOCKS_PER_BAUD - 24'd1;
    end else begin
      busy_r <= 1'b0;
    end
  end

  assign uart_tx = ~line_n;
  assign busy    = busy_r;

endmodule

// File: rtl/txhex_fmt.sv
// Formats a DW-bit word as ASCII hex on a UART: optional "0x", MSB-first
// digits (optionally without leading zeros), then "\r\n".
// Ports:
//   i_clk, i_reset - clock, synchronous active-high reset
//   i_stb          - request strobe, taken only while o_busy is low
//   i_data         - value to print
//   i_prefix       - emit "0x" first
//   i_zsup         - drop leading zero digits (the last digit is always sent)
//   i_upper        - digits a-f as "A"-"F"
//   o_busy         - request in progress or UART still shifting
//   o_done         - one-cycle pulse when "\n" is taken by the UART
//   o_uart_tx      - serial line
// DW must be a multiple of 4 in 4..64.
module txhex_fmt
  import txhex_pkg::*;
#(
  parameter int UART_SETUP = 868,
  parameter int DW         = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_stb,
  input  logic [DW-1:0] i_data,
  input  logic          i_prefix,
  input  logic          i_zsup,
  input  logic          i_upper,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_uart_tx
);

  localparam int ND = DW / 4;
  localparam int CW = $clog2(ND + 1);

  state_t        state;
  logic [DW-1:0] sreg;
  logic [CW-1:0] cnt;
  logic          zsup_q;
  logic          upper_q;
  logic          seen_nz;

  logic          tx_stb;
  logic          tx_busy;
  logic [7:0]    tx_data;
  logic [3:0]    nibble;
  logic          skip;
  logic          consume;

  assign nibble = sreg[DW-1 -: 4];

  // A leading zero is dropped without a UART handshake, one cycle each.
  assign skip    = (state == S_DIG) && zsup_q && !seen_nz
                   && (nibble == 4'h0) && (cnt > CW'(1));
  assign tx_stb  = (state != S_IDLE) && !skip;
  assign consume = tx_stb && !tx_busy;
  assign o_done  = (state == S_LF) && !tx_busy;
  assign o_busy  = (state != S_IDLE) || tx_busy;

  always_comb begin
    tx_data = CH_ZERO;
    case (state)
      S_PFX0:  tx_data = CH_ZERO;
      S_PFXX:  tx_data = CH_X;
      S_DIG:   tx_data = hex2ascii(nibble, upper_q);
      S_CR:    tx_data = CH_CR;
      S_LF:    tx_data = CH_LF;
      default: tx_data = CH_ZERO;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= S_IDLE;
      sreg    <= '0;
      cnt     <= '0;
      zsup_q  <= 1'b0;
      upper_q <= 1'b0;
      seen_nz <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_stb && !o_busy) begin
            sreg    <= i_data;
            zsup_q  <= i_zsup;
            upper_q <= i_upper;
            cnt     <= CW'(ND);
            seen_nz <= 1'b0;
            state   <= i_prefix ? S_PFX0 : S_DIG;
          end
        end
        S_PFX0: if (consume) state <= S_PFXX;
        S_PFXX: if (consume) state <= S_DIG;
        S_DIG: begin
          if (skip || consume) begin
            sreg <= sreg << 4;
            cnt  <= cnt - CW'(1);
            if (!skip) seen_nz <= 1'b1;
            // skip implies cnt > 1, so only a sent digit can end the field
            if (cnt == CW'(1)) state <= S_CR;
          end
        end
        S_CR:    if (consume) state <= S_LF;
        S_LF:    if (consume) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FORMAL
  // Free-running UART stand-in: it must go busy right after taking a character.
  (* anyseq *) logic f_busy;
  (* anyseq *) logic f_tx;
  logic f_taken;

  assign tx_busy   = f_busy;
  assign o_uart_tx = f_tx;

  always_ff @(posedge i_clk) begin
    if (i_reset) f_taken <= 1'b0;
    else         f_taken <= consume;
  end

  always_comb begin
    if (f_taken) assume (tx_busy);
  end
`else
  txuart #(
    .CLOCKS_PER_BAUD(24'(UART_SETUP))
  ) u_txuart (
    .clk     (i_clk),
    .wr      (tx_stb),
    .data    (tx_data),
    .uart_tx (o_uart_tx),
    .busy    (tx_busy)
  );
`endif

endmodule

// File: doc/txhex_fmt.md
Name: txhex_fmt

Overview:
- Parametrised successor to the fixed 32-bit hex transmitter.
- Accepts a DW-bit word and serialises it as ASCII hex to the UART: optional "0x" prefix, MSB-first digits, then "\r\n".
- Per-request options: upper/lower case and leading-zero suppression.
- Sits between debug/status logic and the existing txuart; one request in flight at a time.

Parameters:
- UART_SETUP, 868, clocks per baud passed to txuart (24 bits used).
- DW, 32, data width; multiple of 4, range 4..64; ND = DW/4 digits.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset
- i_stb  in  1  request strobe; accepted only when o_busy low
- i_data  in  DW  value to print
- i_prefix  in  1  emit "0x" before the digits
- i_zsup  in  1  suppress leading zero digits; at least one digit is always sent
- i_upper  in  1  digits a-f sent as "A"-"F"
- o_busy  out  1  request in progress or UART still shifting
- o_done  out  1  one-cycle pulse when "\n" is accepted by the UART
- o_uart_tx  out  1  serial line; idles high

Behaviour:
- Reset: i_reset, synchronous, active-high; clock i_clk. Reset wins over a same-cycle i_stb.
- Reset values: FSM=IDLE, tx_stb=0, o_done=0, shift register=0.
- o_busy = (FSM != IDLE) || tx_busy. At power-up o_busy=0.
- Accept: on i_stb && !o_busy, latch i_data into sreg[DW-1:0], latch prefix/zsup/upper, set digit count to ND, clear seen_nz.
  - Next state is PFX0 if prefix, else DIG.
  - i_stb while o_busy is ignored; latched data and options stay unchanged.
- Character handshake to txuart:
  - tx_stb is held high with tx_data stable until a cycle with tx_stb && !tx_busy.
  - On that cycle the character is consumed and the FSM advances.
  - The next character is presented on the following cycle.
- States:
  - IDLE
  - PFX0: sends "0", then PFXX.
  - PFXX: sends "x", then DIG.
  - DIG: current nibble is sreg[DW-1:DW-4]. On each consumed or skipped digit, shift sreg left 4 and decrement the count. Count reaching 0 -> CR.
  - CR: sends "\r", then LF.
  - LF: sends "\n", pulses o_done the same cycle, then IDLE.
- Zero suppression, in DIG with zsup && !seen_nz && nibble==0 && count>1:
  - The digit is skipped: tx_stb low, one cycle per skipped digit.
  - Any sent digit sets seen_nz.
  - The last digit is always sent, so a zero value yields "0".
- Nibble-to-ASCII:
  - 0-9 -> 0x30-0x39.
  - a-f -> 0x61-0x66, or 0x41-0x46 when upper.
  - Computed combinationally from the current nibble. No stale-register latency: tx_data reflects the current sreg.
- Widths:
  - Digit counter is $clog2(ND+1) bits.
  - Total characters = 2*prefix + (ND - suppressed) + 2; max ND+4.
- Reset mid-operation:
  - FSM returns to IDLE, tx_stb drops the next cycle, no further characters are issued.
  - txuart (no reset) finishes its current character. o_busy stays high until tx_busy falls.
- Back-to-back: a new i_stb is accepted the first cycle o_busy is low after o_done.

Decomposition:
- Shared package txhex_pkg:
  - state encoding (IDLE, PFX0, PFXX, DIG, CR, LF)
  - character constants ("0", "x", CR, LF)
  - function hex2ascii(nibble, upper)
- Sub-module: existing txuart, instantiated with UART_SETUP[23:0], driven by tx_stb/tx_data, returning tx_busy.
- Under FORMAL, replace txuart with anyseq busy/out. Use the same busy-assumption scheme as the current hex transmitter's proofs.

Test Plan:
- All scenarios use UART_SETUP=8.
- DW=32, data=0x12345678, prefix=1, zsup=0, upper=0 -> UART decodes "0x12345678\r\n" (12 chars); o_done once; o_busy falls after the final stop bit.
- DW=32, data=0x0000ABCD, prefix=0, zsup=1, upper=1 -> "ABCD\r\n"; 4 skip cycles with tx_stb low.
- DW=32, data=0, prefix=1, zsup=1 -> "0x0\r\n".
- DW=12, data=0xfff, prefix=1, zsup=0, upper=0 -> "0xfff\r\n"; data=0x00a, zsup=1 -> "0xa\r\n".
- During transmission, pulse i_stb with data=0xDEADBEEF -> ignored; original string completes unchanged; exactly one o_done.
- Assert i_reset while the 3rd digit is in flight -> tx_stb low next cycle; only the in-flight char completes; o_busy low when tx_busy falls. A following request for 0x1 (prefix=0, zsup=1) -> "1\r\n".
